writeback_rf: RTL and testbench

- Parametrised successor of the bf8b writeback stage: owns the architectural register file and commits results from execute under the existing `en`/`ready` handshake.
- Adds generic data width and register count.
- Adds an optional hardwired zero register and two combinational read ports with same-cycle bypass of a committing write.
- Adds a retire counter, an explicit three-state FSM and an asynchronous active-low reset.

---
 rtl/writeback_rf.sv | 168 ++++++++++++++++
 tb/tb_writeback_rf.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/writeback_rf.sv
// Writeback stage: holds the architectural register file and commits results from execute.
// Latency: request sampled at edge N, so the write and ready become visible after edge N+1; 3 cycles per instruction.
// Backpressure: en is held until ready is seen; dropping en in COMMIT cancels the request, dropping it in DONE ends it.
//
// Ports:
//   clk, rst_n           clock and asynchronous active-low reset
//   en, op, reg_addr, val  retire request and its payload (sampled only in IDLE)
//   rd_addr_a/b, rd_data_a/b  two combinational read ports with bypass of the committing write
//   ready, busy, wrote   handshake acknowledge, activity flag, one-cycle write pulse
//   retire_count         instructions retired since reset (wraps)
module writeback_rf #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int OP_W     = 4,
  parameter int CNT_W    = 16,
  parameter int ZERO_REG = 0,
  parameter logic [OP_W-1:0] OP_LOD  = 4'b0001,
  parameter logic [OP_W-1:0] OP_ADD  = 4'b0011,
  parameter logic [OP_W-1:0] OP_ADDI = 4'b0100,
  parameter logic [OP_W-1:0] OP_LODI = 4'b0101,
  parameter logic [OP_W-1:0] OP_NAND = 4'b0110
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [OP_W-1:0]   op,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic [DATA_W-1:0] val,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              ready,
  output logic              busy,
  output logic              wrote,
  output logic [CNT_W-1:0]  retire_count
);

  localparam int NREGS = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COMMIT = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t state, state_nx;

  // Holding registers: the request payload is frozen at capture so execute
  // may change its outputs while it waits for ready.
  logic [OP_W-1:0]   hold_op;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_val;

  logic [DATA_W-1:0] regs [NREGS];

  logic              capture;
  logic              commit_fire;
  logic              hold_wb;
  logic              hold_zero;
  logic              do_write;
  logic              bypass_ok;
  logic              ready_q;
  logic              wrote_q;
  logic [CNT_W-1:0]  cnt_q;

  function automatic logic is_wb_op(input logic [OP_W-1:0] o);
    return (o == OP_LOD) || (o == OP_ADD) || (o == OP_ADDI) ||
           (o == OP_LODI) || (o == OP_NAND);
  endfunction

  assign hold_wb   = is_wb_op(hold_op);
  // Writes aimed at a hardwired zero register retire but are dropped.
  assign hold_zero = (ZERO_REG != 0) && (hold_addr == '0);
  assign do_write  = commit_fire && hold_wb && !hold_zero;
  // The committing value is visible on the read ports in the same cycle it is written.
  assign bypass_ok = (state == S_COMMIT) && en && hold_wb;

  // Next-state logic
  always_comb begin
    state_nx    = state;
    capture     = 1'b0;
    commit_fire = 1'b0;
    case (state)
      S_IDLE: begin
        if (en) begin
          capture  = 1'b1;
          state_nx = S_COMMIT;
        end
      end
      S_COMMIT: begin
        if (en) begin
          commit_fire = 1'b1;
          state_nx    = S_DONE;
        end else begin
          // Request withdrawn before commit: nothing is written or counted.
          state_nx = S_IDLE;
        end
      end
      S_DONE: begin
        if (!en) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State and holding registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      hold_op   <= '0;
      hold_addr <= '0;
      hold_val  <= '0;
    end else begin
      state <= state_nx;
      if (capture) begin
        hold_op   <= op;
        hold_addr <= reg_addr;
        hold_val  <= val;
      end
    end
  end

  // Register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (do_write) begin
      regs[hold_addr] <= hold_val;
    end
  end

  // Handshake, write pulse and retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      wrote_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      wrote_q <= do_write;
      if (commit_fire) begin
        ready_q <= 1'b1;
        cnt_q   <= cnt_q + 1'b1;
      end else if ((state == S_DONE) && !en) begin
        ready_q <= 1'b0;
      end
    end
  end

  // Read ports: zero register first, then bypass, then array.
  always_comb begin
    rd_data_a = regs[rd_addr_a];
    if (bypass_ok && (rd_addr_a == hold_addr)) rd_data_a = hold_val;
    if ((ZERO_REG != 0) && (rd_addr_a == '0)) rd_data_a = '0;
  end

  always_comb begin
    rd_data_b = regs[rd_addr_b];
    if (bypass_ok && (rd_addr_b == hold_addr)) rd_data_b = hold_val;
    if ((ZERO_REG != 0) && (rd_addr_b == '0)) rd_data_b = '0;
  end

  assign ready        = ready_q;
  assign busy         = (state != S_IDLE);
  assign wrote        = wrote_q;
  assign retire_count = cnt_q;

endmodule

// File: tb/tb_writeback_rf.sv
// Bench for writeback_rf: two instances share stimulus, one with default
// parameters and one with a hardwired zero register and a 2-bit retire counter.
// A request-level model predicts every output on each falling clock edge.
module tb_writeback_rf;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] op;
  logic [3:0] reg_addr;
  logic [7:0] val;
  logic [3:0] rd_addr_a;
  logic [3:0] rd_addr_b;

  logic [7:0]  rd_a0, rd_b0, rd_a1, rd_b1;
  logic        ready0, busy0, wrote0, ready1, busy1, wrote1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  writeback_rf dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .op(op), .reg_addr(reg_addr), .val(val),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_a0), .rd_addr_b(rd_addr_b), .rd_data_b(rd_b0),
    .ready(ready0), .busy(busy0), .wrote(wrote0), .retire_count(cnt0)
  );

  writeback_rf #(.ZERO_REG(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .op(op), .reg_addr(reg_addr), .val(val),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_a1), .rd_addr_b(rd_addr_b), .rd_data_b(rd_b1),
    .ready(ready1), .busy(busy1), .wrote(wrote1), .retire_count(cnt1)
  );

  // ---------------- model ----------------
  // A request is tracked by how many consecutive sampled edges en has been
  // high: 1 = captured, 2 = committed and acknowledged.
  int         run = 0;
  logic [3:0] m_op = '0;
  logic [3:0] m_addr = '0;
  logic [7:0] m_val = '0;
  logic [7:0] m_rf0 [16];
  logic [7:0] m_rf1 [16];
  int         m_cnt0 = 0;
  int         m_cnt1 = 0;
  bit         m_wr0 = 0;
  bit         m_wr1 = 0;

  function automatic bit writes_back(input logic [3:0] o);
    return o == 4'b0001 || o == 4'b0011 || o == 4'b0100 || o == 4'b0101 || o == 4'b0110;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run = 0; m_op = '0; m_addr = '0; m_val = '0;
      m_cnt0 = 0; m_cnt1 = 0; m_wr0 = 0; m_wr1 = 0;
      for (int i = 0; i < 16; i++) begin m_rf0[i] = '0; m_rf1[i] = '0; end
    end else begin
      m_wr0 = 0; m_wr1 = 0;
      if (!en) run = 0;
      else if (run == 0) begin
        run = 1; m_op = op; m_addr = reg_addr; m_val = val;
      end else if (run == 1) begin
        run = 2;
        m_cnt0 = (m_cnt0 + 1) % 65536;
        m_cnt1 = (m_cnt1 + 1) % 4;
        if (writes_back(m_op)) begin
          m_rf0[m_addr] = m_val; m_wr0 = 1;
          if (m_addr != 0) begin m_rf1[m_addr] = m_val; m_wr1 = 1; end
        end
      end
    end
  end

  function automatic logic [7:0] exp_rd(input bit zr, input logic [3:0] a);
    if (zr && a == 0) return 8'h00;
    if (run == 1 && en && writes_back(m_op) && a == m_addr) return m_val;
    return zr ? m_rf1[a] : m_rf0[a];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("ready0", {31'd0, ready0}, {31'd0, run == 2});
    chk("busy0",  {31'd0, busy0},  {31'd0, run != 0});
    chk("wrote0", {31'd0, wrote0}, {31'd0, m_wr0});
    chk("count0", {16'd0, cnt0}, m_cnt0);
    chk("rd_a0",  {24'd0, rd_a0}, {24'd0, exp_rd(0, rd_addr_a)});
    chk("rd_b0",  {24'd0, rd_b0}, {24'd0, exp_rd(0, rd_addr_b)});
    chk("ready1", {31'd0, ready1}, {31'd0, run == 2});
    chk("busy1",  {31'd0, busy1},  {31'd0, run != 0});
    chk("wrote1", {31'd0, wrote1}, {31'd0, m_wr1});
    chk("count1", {30'd0, cnt1}, m_cnt1);
    chk("rd_a1",  {24'd0, rd_a1}, {24'd0, exp_rd(1, rd_addr_a)});
    chk("rd_b1",  {24'd0, rd_b1}, {24'd0, exp_rd(1, rd_addr_b)});
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic e, input logic [3:0] o, input logic [3:0] a, input logic [7:0] v);
    @(posedge clk);
    #2;
    en = e; op = o; reg_addr = a; val = v;
  endtask

  // Full request: capture, commit, then drop en (ends in DONE with ready high).
  task automatic instr(input logic [3:0] o, input logic [3:0] a, input logic [7:0] v);
    step(1'b1, o, a, v);
    step(1'b1, o, a, v);
    step(1'b0, o, a, v);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0; op = '0; reg_addr = '0; val = '0;
    rd_addr_a = '0; rd_addr_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", {31'd0, ready0}, 32'd0);
    chk("reset_count", {16'd0, cnt0}, 32'd0);
    #1 rst_n = 1'b1;

    // ADD r5 = 0x3C
    rd_addr_a = 4'd5;
    instr(4'b0011, 4'd5, 8'h3C);
    chk("add_ready", {31'd0, ready0}, 32'd1);
    chk("add_wrote", {31'd0, wrote0}, 32'd1);
    chk("add_count", {16'd0, cnt0}, 32'd1);
    chk("add_rd5",   {24'd0, rd_a0}, 32'h3C);
    step(1'b0, 4'b0000, 4'd0, 8'h00);
    #1;
    chk("add_ready_drop", {31'd0, ready0}, 32'd0);

    // Non-writing opcode
    rd_addr_a = 4'd2;
    instr(4'b0010, 4'd2, 8'hFF);
    chk("nop_ready", {31'd0, ready0}, 32'd1);
    chk("nop_wrote", {31'd0, wrote0}, 32'd0);
    chk("nop_r2",    {24'd0, rd_a0}, 32'h00);
    chk("nop_count", {16'd0, cnt0}, 32'd2);

    // Withdrawn request
    step(1'b0, 4'b0000, 4'd0, 8'h00);
    rd_addr_a = 4'd7;
    step(1'b1, 4'b0101, 4'd7, 8'h11);
    step(1'b0, 4'b0101, 4'd7, 8'h11);
    step(1'b0, 4'b0101, 4'd7, 8'h11);
    #1;
    chk("wd_ready", {31'd0, ready0}, 32'd0);
    chk("wd_r7",    {24'd0, rd_a0}, 32'h00);
    chk("wd_count", {16'd0, cnt0}, 32'd2);

    // Bypass during COMMIT, payload change after capture is ignored
    rd_addr_b = 4'd3;
    step(1'b1, 4'b0101, 4'd3, 8'hA5);
    step(1'b1, 4'b0101, 4'd3, 8'h00);
    #1;
    chk("byp_rd_b", {24'd0, rd_b0}, 32'hA5);
    step(1'b0, 4'b0101, 4'd3, 8'h00);
    #1;
    chk("byp_r3",    {24'd0, rd_b0}, 32'hA5);
    chk("byp_wrote", {31'd0, wrote0}, 32'd1);

    // Write to register 0: dropped only in the zero-register instance
    rd_addr_a = 4'd0;
    instr(4'b0101, 4'd0, 8'h77);
    chk("zr_wrote1", {31'd0, wrote1}, 32'd0);
    chk("zr_rd1",    {24'd0, rd_a1}, 32'h00);
    chk("zr_ready1", {31'd0, ready1}, 32'd1);
    chk("zr_count1", {30'd0, cnt1}, 32'd0);
    chk("zr_rd0",    {24'd0, rd_a0}, 32'h77);
    chk("zr_count0", {16'd0, cnt0}, 32'd4);

    // Asynchronous reset in the middle of a COMMIT
    rd_addr_a = 4'd9;
    step(1'b1, 4'b0011, 4'd9, 8'h42);
    step(1'b1, 4'b0011, 4'd9, 8'h42);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_ready", {31'd0, ready0}, 32'd0);
    chk("ar_busy",  {31'd0, busy0}, 32'd0);
    chk("ar_count", {16'd0, cnt0}, 32'd0);
    chk("ar_r9",    {24'd0, rd_a0}, 32'h00);
    en = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("ar_r9_after", {24'd0, rd_a0}, 32'h00);

    // Four retires wrap the 2-bit counter
    for (int i = 0; i < 4; i++) begin
      rd_addr_b = 4'(i + 1);
      instr(4'b0110, 4'(i + 1), 8'(i * 16 + 1));
    end
    chk("wrap_count1", {30'd0, cnt1}, 32'd0);
    chk("wrap_count0", {16'd0, cnt0}, 32'd4);
    chk("wrap_r4",     {24'd0, rd_b1}, 32'h31);
    step(1'b0, 4'b0000, 4'd0, 8'h00);
    step(1'b0, 4'b0000, 4'd0, 8'h00);
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
